// File: rtl/pipelined_alu_if.sv
// Operand/result handshake bundle for pipelined_alu.
// The master drives operands and consumes results; the slave is the ALU.
interface pipelined_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [2:0]       command;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             zero;
  logic             overflow;
  logic             sticky_overflow;
  logic             clear_sticky;

  modport master (
    output in_valid, operand_a, operand_b, command, out_ready, clear_sticky,
    input  in_ready, out_valid, result, carryout, zero, overflow, sticky_overflow
  );

  modport slave (
    input  in_valid, operand_a, operand_b, command, out_ready, clear_sticky,
    output in_ready, out_valid, result, carryout, zero, overflow, sticky_overflow
  );
endinterface

// File: rtl/pipelined_alu.sv
// Two-stage ALU: S1 captures operands, S2 holds result and flags.
// Valid/ready on both sides with full backpressure; sticky overflow on delivery.
module pipelined_alu #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  pipelined_alu_if.slave alu_bus
);
  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } cmd_e;

  localparam int MSB = WIDTH - 1;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  cmd_e             r_s1_cmd;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_ovf;
  logic             r_sticky;

  logic             w_s2_en;
  logic             w_s1_en;
  logic [WIDTH:0]   w_add_sum;
  logic [WIDTH:0]   w_sub_sum;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_ovf;

  assign w_s2_en          = !r_out_valid || alu_bus.out_ready;
  assign w_s1_en          = !r_s1_valid || w_s2_en;
  assign alu_bus.in_ready = w_s1_en && !reset;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= alu_bus.in_valid;
    end
  end

  // NOTE: operand registers have no reset; r_s1_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (w_s1_en && alu_bus.in_valid) begin
      r_s1_a   <= alu_bus.operand_a;
      r_s1_b   <= alu_bus.operand_b;
      r_s1_cmd <= cmd_e'(alu_bus.command);
    end
  end

  assign w_add_sum = {1'b0, r_s1_a} + {1'b0, r_s1_b};
  assign w_sub_sum = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_add_ovf = (r_s1_a[MSB] == r_s1_b[MSB])  && (w_add_sum[MSB] != r_s1_a[MSB]);
  assign w_sub_ovf = (r_s1_a[MSB] == !r_s1_b[MSB]) && (w_sub_sum[MSB] != r_s1_a[MSB]);

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    case (r_s1_cmd)
      CMD_ADD: begin
        w_result = w_add_sum[MSB:0];
        w_carry  = w_add_sum[WIDTH];
        w_ovf    = w_add_ovf;
      end
      CMD_SUB: begin
        w_result = w_sub_sum[MSB:0];
        w_carry  = w_sub_sum[WIDTH];
        w_ovf    = w_sub_ovf;
      end
      CMD_XOR:  w_result = r_s1_a ^ r_s1_b;
      CMD_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_sub_sum[MSB] ^ w_sub_ovf};
      CMD_AND:  w_result = r_s1_a & r_s1_b;
      CMD_NAND: w_result = ~(r_s1_a & r_s1_b);
      CMD_NOR:  w_result = ~(r_s1_a | r_s1_b);
      CMD_OR:   w_result = r_s1_a | r_s1_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_result;
        r_carry  <= w_carry;
        r_ovf    <= w_ovf;
      end
    end
  end

  // A delivery with overflow takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky <= 1'b0;
    end else if (r_out_valid && alu_bus.out_ready && r_ovf) begin
      r_sticky <= 1'b1;
    end else if (alu_bus.clear_sticky) begin
      r_sticky <= 1'b0;
    end
  end

  assign alu_bus.out_valid       = r_out_valid;
  assign alu_bus.result          = r_result;
  assign alu_bus.carryout        = r_carry;
  assign alu_bus.overflow        = r_ovf;
  assign alu_bus.zero            = r_out_valid && (r_result == '0);
  assign alu_bus.sticky_overflow = r_sticky;
endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu: directed literal cases plus random traffic
// compared against an arithmetic reference model on every delivered result.
module tb_pipelined_alu;
  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipelined_alu_if #(.WIDTH(32)) bus32 ();
  pipelined_alu_if #(.WIDTH(8))  bus8 ();

  pipelined_alu #(.WIDTH(32)) u_dut   (.clk(clk), .reset(reset), .alu_bus(bus32));
  pipelined_alu #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .alu_bus(bus8));

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  exp_t        exp_q[$];
  logic [31:0] dlv_res[$];
  int          dlv_cyc[$];
  logic        model_sticky = 1'b0;
  logic        prev_stall   = 1'b0;
  logic [31:0] prev_res;
  exp_t        mon_e;
  logic        mon_dv;

  logic [31:0] s3_a[8] = '{32'd3, 32'd10, 32'hFF00FF00, 32'hFFFFFFFF,
                           32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0, 32'h12340000};
  logic [31:0] s3_b[8] = '{32'd4, 32'd3, 32'h0FF00FF0, 32'h0,
                           32'hFF00FF00, 32'hFF00FF00, 32'h0, 32'h00005678};
  logic [31:0] s3_r[8] = '{32'd7, 32'd7, 32'hF0F0F0F0, 32'd1,
                           32'hF000F000, 32'h0FFF0FFF, 32'hFFFFFFFF, 32'h12345678};
  logic [31:0] s4_a[4] = '{32'd1, 32'd9, 32'd1, 32'd5};
  logic [31:0] s4_b[4] = '{32'd1, 32'd2, 32'd8, 32'd3};
  logic [2:0]  s4_c[4] = '{3'd0, 3'd1, 3'd7, 3'd2};
  logic [31:0] s4_r[4] = '{32'd2, 32'd7, 32'd9, 32'd6};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
    exp_t   e;
    longint sa, sb, s, ua, ub, u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    e.r = '0;
    e.c = 1'b0;
    e.v = 1'b0;
    case (cmd)
      3'd0: begin
        u   = ua + ub;
        e.r = u[31:0];
        e.c = u[32];
        s   = sa + sb;
        e.v = (s > MAX_S) || (s < MIN_S);
      end
      3'd1: begin
        e.r = a - b;
        e.c = (a >= b);
        s   = sa - sb;
        e.v = (s > MAX_S) || (s < MIN_S);
      end
      3'd2: e.r = a ^ b;
      3'd3: e.r = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: e.r = a & b;
      3'd5: e.r = ~(a & b);
      3'd6: e.r = ~(a | b);
      default: e.r = a | b;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Compare process: inputs change just after the rising edge, so the falling edge sees stable values.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("ready_in_reset", bus32.in_ready, 1'b0);
      exp_q.delete();
      model_sticky = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      check("sticky", bus32.sticky_overflow, model_sticky);
      if (prev_stall) begin
        check("stall_valid", bus32.out_valid, 1'b1);
        check("stall_hold", bus32.result, prev_res);
      end
      mon_dv = 1'b0;
      if (bus32.out_valid && bus32.out_ready) begin
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_output");
        end else begin
          mon_e = exp_q.pop_front();
          check("result", bus32.result, mon_e.r);
          check("carry", bus32.carryout, mon_e.c);
          check("ovf", bus32.overflow, mon_e.v);
          check("zero", bus32.zero, mon_e.r == 32'h0);
          mon_dv = mon_e.v;
        end
        dlv_res.push_back(bus32.result);
        dlv_cyc.push_back(cyc);
      end
      if (mon_dv) model_sticky = 1'b1;
      else if (bus32.clear_sticky) model_sticky = 1'b0;
      if (bus32.in_valid && bus32.in_ready)
        exp_q.push_back(model(bus32.operand_a, bus32.operand_b, bus32.command));
      prev_stall = bus32.out_valid && !bus32.out_ready;
      prev_res   = bus32.result;
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                       output logic [31:0] r, output logic co, output logic z,
                       output logic ov, output int lat);
    int g;
    @(posedge clk); #1;
    bus32.in_valid  = 1'b1;
    bus32.operand_a = a;
    bus32.operand_b = b;
    bus32.command   = c;
    g = 0;
    @(negedge clk);
    while (!bus32.in_ready && g < 20) begin g++; @(negedge clk); end
    if (!bus32.in_ready) timeout_fail("op_accept");
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    lat = 1;
    g   = 0;
    @(negedge clk);
    while (!bus32.out_valid && g < 20) begin g++; lat++; @(negedge clk); end
    if (!bus32.out_valid) timeout_fail("op_result");
    r  = bus32.result;
    co = bus32.carryout;
    z  = bus32.zero;
    ov = bus32.overflow;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c,
                        output logic [7:0] r, output logic co, output logic z, output logic ov);
    int g;
    @(posedge clk); #1;
    bus8.in_valid  = 1'b1;
    bus8.operand_a = a;
    bus8.operand_b = b;
    bus8.command   = c;
    @(negedge clk);
    if (!bus8.in_ready) timeout_fail("op8_accept");
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    g = 0;
    @(negedge clk);
    while (!bus8.out_valid && g < 20) begin g++; @(negedge clk); end
    if (!bus8.out_valid) timeout_fail("op8_result");
    r  = bus8.result;
    co = bus8.carryout;
    z  = bus8.zero;
    ov = bus8.overflow;
  endtask

  task automatic wait_dlv(input int n, input string name);
    int g;
    g = 0;
    while (dlv_res.size() < n && g < 40) begin g++; @(negedge clk); end
    if (dlv_res.size() < n) timeout_fail(name);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  r8;
    logic        co, z, ov;
    int          lat, idx, g;
    logic [31:0] held;

    reset              = 1'b1;
    bus32.in_valid     = 1'b0;
    bus32.operand_a    = '0;
    bus32.operand_b    = '0;
    bus32.command      = '0;
    bus32.out_ready    = 1'b1;
    bus32.clear_sticky = 1'b0;
    bus8.in_valid      = 1'b0;
    bus8.operand_a     = '0;
    bus8.operand_b     = '0;
    bus8.command       = '0;
    bus8.out_ready     = 1'b1;
    bus8.clear_sticky  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus32.out_valid, 1'b0);
    check("rst_result", bus32.result, 32'h0);
    check("rst_carry", bus32.carryout, 1'b0);
    check("rst_zero", bus32.zero, 1'b0);
    check("rst_ovf", bus32.overflow, 1'b0);
    check("rst_sticky", bus32.sticky_overflow, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus32.in_ready, 1'b1);

    // Signed overflow on ADD, two-cycle latency, sticky set on delivery.
    do_op(32'h7FFFFFFF, 32'h1, 3'd0, r, co, z, ov, lat);
    check("t1_latency", lat, 2);
    check("t1_result", r, 32'h80000000);
    check("t1_ovf", ov, 1'b1);
    check("t1_carry", co, 1'b0);
    check("t1_zero", z, 1'b0);
    @(negedge clk);
    check("t1_sticky", bus32.sticky_overflow, 1'b1);
    @(posedge clk); #1;
    bus32.clear_sticky = 1'b1;
    @(posedge clk); #1;
    bus32.clear_sticky = 1'b0;
    @(negedge clk);
    check("t1_sticky_clear", bus32.sticky_overflow, 1'b0);

    do_op(32'd5, 32'd5, 3'd1, r, co, z, ov, lat);
    check("t2_sub_result", r, 32'h0);
    check("t2_sub_zero", z, 1'b1);
    check("t2_sub_carry", co, 1'b1);
    check("t2_sub_ovf", ov, 1'b0);
    do_op(32'h80000000, 32'h1, 3'd3, r, co, z, ov, lat);
    check("t2_slt_neg", r, 32'h1);
    do_op(32'h1, 32'h80000000, 3'd3, r, co, z, ov, lat);
    check("t2_slt_pos", r, 32'h0);

    // Back-to-back stream of all eight commands.
    @(negedge clk);
    dlv_res.delete();
    dlv_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus32.in_valid  = 1'b1;
      bus32.operand_a = s3_a[i];
      bus32.operand_b = s3_b[i];
      bus32.command   = 3'(i);
      @(negedge clk);
      check("t3_ready", bus32.in_ready, 1'b1);
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    wait_dlv(8, "t3_deliver");
    for (int i = 0; i < 8 && i < dlv_res.size(); i++) begin
      check("t3_result", dlv_res[i], s3_r[i]);
      check("t3_consecutive", dlv_cyc[i] - dlv_cyc[0], i);
    end

    // Backpressure: S1 and S2 fill, then in_ready drops and outputs hold.
    dlv_res.delete();
    dlv_cyc.delete();
    idx  = 0;
    held = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      bus32.out_ready = 1'b0;
      bus32.in_valid  = 1'b1;
      bus32.operand_a = s4_a[idx];
      bus32.operand_b = s4_b[idx];
      bus32.command   = s4_c[idx];
      @(negedge clk);
      if (k == 2) held = bus32.result;
      if (k == 3) check("t4_held", bus32.result, held);
      if (bus32.in_ready) idx++;
    end
    check("t4_accepts", idx, 2);
    check("t4_ready_low", bus32.in_ready, 1'b0);
    g = 0;
    while (idx < 4 && g < 20) begin
      g++;
      @(posedge clk); #1;
      bus32.out_ready = 1'b1;
      bus32.in_valid  = 1'b1;
      bus32.operand_a = s4_a[idx];
      bus32.operand_b = s4_b[idx];
      bus32.command   = s4_c[idx];
      @(negedge clk);
      if (bus32.in_ready) idx++;
    end
    if (idx < 4) timeout_fail("t4_accept_rest");
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    wait_dlv(4, "t4_deliver");
    repeat (3) @(negedge clk);
    check("t4_count", dlv_res.size(), 4);
    for (int i = 0; i < 4 && i < dlv_res.size(); i++) check("t4_order", dlv_res[i], s4_r[i]);

    // Reset with both stages full discards everything.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      bus32.out_ready = 1'b0;
      bus32.in_valid  = 1'b1;
      bus32.operand_a = 32'h7FFFFFFF;
      bus32.operand_b = 32'h7FFFFFFF;
      bus32.command   = 3'd0;
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    reset          = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dlv_res.delete();
    dlv_cyc.delete();
    @(negedge clk);
    check("t5_out_valid", bus32.out_valid, 1'b0);
    check("t5_in_ready", bus32.in_ready, 1'b1);
    check("t5_result", bus32.result, 32'h0);
    check("t5_carry", bus32.carryout, 1'b0);
    check("t5_zero", bus32.zero, 1'b0);
    check("t5_ovf", bus32.overflow, 1'b0);
    check("t5_sticky", bus32.sticky_overflow, 1'b0);
    @(posedge clk); #1;
    bus32.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_discarded", dlv_res.size(), 0);

    // Clear coincident with an overflow delivery: set wins.
    @(posedge clk); #1;
    bus32.clear_sticky = 1'b1;
    bus32.in_valid     = 1'b1;
    bus32.operand_a    = 32'h80000000;
    bus32.operand_b    = 32'h00000001;
    bus32.command      = 3'd1;
    @(negedge clk);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    g = 0;
    @(negedge clk);
    while (!bus32.out_valid && g < 20) begin g++; @(negedge clk); end
    if (!bus32.out_valid) timeout_fail("t5_ovf_result");
    check("t5_sub_ovf", bus32.overflow, 1'b1);
    @(posedge clk); #1;
    bus32.clear_sticky = 1'b0;
    @(negedge clk);
    check("t5_set_wins", bus32.sticky_overflow, 1'b1);

    // Narrow instance.
    do_op8(8'hFF, 8'h01, 3'd0, r8, co, z, ov);
    check("t6_result", r8, 8'h00);
    check("t6_carry", co, 1'b1);
    check("t6_zero", z, 1'b1);
    check("t6_ovf", ov, 1'b0);
    do_op8(8'h7F, 8'h01, 3'd0, r8, co, z, ov);
    check("t6_ovf_result", r8, 8'h80);
    check("t6_ovf_flag", ov, 1'b1);

    // Random traffic with random backpressure and clears.
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      bus32.in_valid     = ($urandom % 4) != 0;
      bus32.out_ready    = ($urandom % 3) != 0;
      bus32.clear_sticky = ($urandom % 8) == 0;
      bus32.operand_a    = pick();
      bus32.operand_b    = pick();
      bus32.command      = 3'($urandom % 8);
    end
    @(posedge clk); #1;
    bus32.in_valid     = 1'b0;
    bus32.out_ready    = 1'b1;
    bus32.clear_sticky = 1'b0;
    repeat (6) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
